// File: rtl/gcd_engine_if.sv
// ============================================================================
// Module   : gcd_engine_if
// Brief    : Request/result bundle for the subtractive GCD engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gcd_engine_if #(
    parameter int W = 8
);
    logic         start;
    logic [W-1:0] xin;
    logic [W-1:0] yin;
    logic         busy;
    logic         done;
    logic [W-1:0] gcd;
    logic         err;
    logic [W-1:0] iter;

    modport master (
        output start, xin, yin,
        input  busy, done, gcd, err, iter
    );

    modport slave (
        input  start, xin, yin,
        output busy, done, gcd, err, iter
    );
endinterface

`default_nettype wire

// File: rtl/gcd_engine.sv
// ============================================================================
// Module   : gcd_engine
// Brief    : Iterative subtractive GCD with step count and zero-operand error.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gcd_engine #(
    parameter int W = 8
) (
    input  wire logic       clk,
    input  wire logic       clr,
    gcd_engine_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [W-1:0] c_zero = '0;
    localparam logic [W-1:0] c_one  = {{(W-1){1'b0}}, 1'b1};

    state_t       r_state;
    logic [W-1:0] r_x;
    logic [W-1:0] r_y;
    logic [W-1:0] r_cnt;
    logic [W-1:0] r_gcd;
    logic [W-1:0] r_iter;
    logic         r_err;
    logic         r_busy;
    logic         r_done;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_x     <= c_zero;
            r_y     <= c_zero;
            r_cnt   <= c_zero;
            r_gcd   <= c_zero;
            r_iter  <= c_zero;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_busy <= 1'b1;
                        if ((bus.xin != c_zero) && (bus.yin != c_zero)) begin
                            r_x     <= bus.xin;
                            r_y     <= bus.yin;
                            r_cnt   <= c_zero;
                            r_state <= S_CALC;
                        end else begin
                            // A zero operand makes the other one the answer outright.
                            r_gcd   <= bus.xin | bus.yin;
                            r_iter  <= c_zero;
                            r_err   <= (bus.xin == c_zero) && (bus.yin == c_zero);
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end

                S_CALC: begin
                    if (r_x == r_y) begin
                        r_gcd   <= r_x;
                        r_iter  <= r_cnt;
                        r_err   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_x > r_y) begin
                        r_x   <= r_x - r_y;
                        r_cnt <= r_cnt + c_one;
                    end else begin
                        r_y   <= r_y - r_x;
                        r_cnt <= r_cnt + c_one;
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.gcd  = r_gcd;
    assign bus.err  = r_err;
    assign bus.iter = r_iter;

endmodule

`default_nettype wire

// File: tb/tb_gcd_engine.sv
// ============================================================================
// Module   : tb_gcd_engine
// Brief    : Directed and random scoreboard checks of gcd_engine at W=8 and W=4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gcd_engine;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    gcd_engine_if #(.W(8)) b8 ();
    gcd_engine_if #(.W(4)) b4 ();

    gcd_engine #(.W(8)) u_dut8 (.clk(clk), .clr(clr), .bus(b8.slave));
    gcd_engine #(.W(4)) u_dut4 (.clk(clk), .clr(clr), .bus(b4.slave));

    typedef struct {
        logic [7:0] g;
        logic [7:0] it;
        logic       e;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
        exp_t       r;
        logic [7:0] x, y;
        int         n;
        if (a == 8'd0 || b == 8'd0) begin
            r.g = a | b; r.it = 8'd0; r.e = (a == 8'd0) && (b == 8'd0); r.lat = 0;
        end else begin
            x = a; y = b; n = 0;
            while (x != y) begin
                if (x > y) x = x - y; else y = y - x;
                n++;
            end
            r.g = x; r.it = n[7:0]; r.e = 1'b0; r.lat = n + 1;
        end
        return r;
    endfunction

    function automatic logic cur_done(input bit s4);
        return s4 ? b4.done : b8.done;
    endfunction

    function automatic logic cur_busy(input bit s4);
        return s4 ? b4.busy : b8.busy;
    endfunction

    task automatic run_op(input bit s4, input logic [7:0] a_in, input logic [7:0] b_in, input string tag);
        exp_t       e;
        logic [7:0] a, b, og, oi;
        logic       oe;
        int         lat;
        bit         seen, busy_ok;
        a = s4 ? {4'd0, a_in[3:0]} : a_in;
        b = s4 ? {4'd0, b_in[3:0]} : b_in;
        sb.push_back(model(a, b));
        if (s4) begin b4.start = 1'b1; b4.xin = a[3:0]; b4.yin = b[3:0]; end
        else    begin b8.start = 1'b1; b8.xin = a;      b8.yin = b;      end
        @(posedge clk); #1;
        b4.start = 1'b0; b8.start = 1'b0;
        b4.xin = 4'hA; b4.yin = 4'h5; b8.xin = 8'hA5; b8.yin = 8'h5A;
        lat = 0; seen = 1'b0; busy_ok = 1'b1;
        while (!seen && lat < 400) begin
            if (cur_done(s4)) seen = 1'b1;
            else begin
                if (!cur_busy(s4)) busy_ok = 1'b0;
                @(posedge clk); #1;
                lat++;
            end
        end
        e  = sb.pop_front();
        og = s4 ? {4'd0, b4.gcd}  : b8.gcd;
        oi = s4 ? {4'd0, b4.iter} : b8.iter;
        oe = s4 ? b4.err : b8.err;
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " gcd"}, 32'(og), 32'(e.g));
        check({tag, " iter"}, 32'(oi), 32'(e.it));
        check({tag, " err"}, 32'(oe), 32'(e.e));
        check({tag, " latency"}, 32'(lat), 32'(e.lat));
        check({tag, " busy_while_running"}, 32'(busy_ok && cur_busy(s4)), 32'd1);
        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, 32'(cur_done(s4)), 32'd0);
        check({tag, " busy_back_idle"}, 32'(cur_busy(s4)), 32'd0);
    endtask

    initial begin
        logic [9:0] dv;
        bit         ghost;
        b8.start = 1'b0; b8.xin = '0; b8.yin = '0;
        b4.start = 1'b0; b4.xin = '0; b4.yin = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(b8.busy), 32'd0);
        check("reset done", 32'(b8.done), 32'd0);
        check("reset gcd",  32'(b8.gcd),  32'd0);
        check("reset iter", 32'(b8.iter), 32'd0);
        check("reset err",  32'(b8.err),  32'd0);
        clr = 1'b0;
        @(posedge clk); #1;

        run_op(1'b0, 8'd12, 8'd18, "g12_18");
        repeat (3) @(posedge clk);
        #1;
        check("gcd_held", 32'(b8.gcd), 32'd6);
        run_op(1'b0, 8'd0, 8'd9, "g0_9");
        run_op(1'b0, 8'd0, 8'd0, "g0_0");
        run_op(1'b0, 8'd7, 8'd0, "g7_0");
        run_op(1'b0, 8'd255, 8'd1, "g255_1");
        run_op(1'b0, 8'd20, 8'd20, "g20_20");

        // Start held high: the second operation is accepted right after DONE.
        b8.start = 1'b1; b8.xin = 8'd12; b8.yin = 8'd18;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            dv[k] = b8.done;
        end
        b8.start = 1'b0;
        check("start_held_pattern", 32'(dv), 32'(10'b01_0000_1000));
        repeat (3) @(posedge clk);
        #1;

        // Abort a long operation with clr; a mid-flight start must be ignored.
        ghost = 1'b0;
        b8.start = 1'b1; b8.xin = 8'd255; b8.yin = 8'd1;
        @(posedge clk); #1;
        b8.start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (c == 5) begin b8.start = 1'b1; b8.xin = 8'd8; b8.yin = 8'd12; end
            else b8.start = 1'b0;
            @(posedge clk); #1;
            if (b8.done) ghost = 1'b1;
        end
        b8.start = 1'b0;
        check("abort busy_before_clr", 32'(b8.busy), 32'd1);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("abort no_done", 32'(ghost || b8.done), 32'd0);
        check("abort busy", 32'(b8.busy), 32'd0);
        check("abort gcd",  32'(b8.gcd),  32'd0);
        check("abort iter", 32'(b8.iter), 32'd0);
        check("abort err",  32'(b8.err),  32'd0);
        @(posedge clk); #1;
        check("abort still_idle", 32'(b8.busy || b8.done), 32'd0);
        run_op(1'b0, 8'd8, 8'd12, "g8_12_after_clr");

        for (int i = 0; i < 16; i++)
            run_op(1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)), "rnd8");
        run_op(1'b1, 8'd15, 8'd1, "w4_15_1");
        run_op(1'b1, 8'd0, 8'd0, "w4_0_0");
        for (int i = 0; i < 16; i++)
            run_op(1'b1, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), "rnd4");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gcd_engine.md
GCD_ENGINE -- requirements
Module: gcd_engine

Interface
REQ-001 Parameter W, default 8, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 clr  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 xin  input  W  first operand, unsigned; sampled with start.
REQ-006 yin  input  W  second operand, unsigned; sampled with start.
REQ-007 busy  output  1  high while not in IDLE.
REQ-008 done  output  1  single-cycle pulse; result valid.
REQ-009 gcd  output  W  registered result; held until next result is written.
REQ-010 err  output  1  registered; set with done when both operands were zero.
REQ-011 iter  output  W  registered; subtraction steps used for the last result.

Function
REQ-012 FSM states SHALL be IDLE, CALC and DONE; one state register, one-hot or binary at implementer's choice.
REQ-013 IDLE, start=0 -> stay IDLE; no register changes.
REQ-014 IDLE, start=1, xin!=0 and yin!=0 -> load x=xin, y=yin, internal step counter=0, go to CALC.
REQ-015 IDLE, start=1, xin==0 or yin==0 -> gcd=xin|yin, iter=0, err=(xin==0 and yin==0), go to DONE; no CALC cycles.
REQ-016 CALC, x==y -> gcd=x, iter=step counter, err=0, go to DONE.
REQ-017 CALC, x>y -> x=x-y, step counter +1, stay in CALC.
REQ-018 CALC, x<y -> y=y-x, step counter +1, stay in CALC.
REQ-019 Exactly one subtraction per CALC cycle; compare and subtract use the current x and y only.
REQ-020 All subtractions are W-bit unsigned; results never underflow because the larger value is always the minuend.
REQ-021 The step counter is W bits and never wraps; worst case (2^W-1, 1) needs 2^W-2 steps.
REQ-022 DONE -> done=1 for exactly that cycle, go to IDLE unconditionally.
REQ-023 Latency: with n subtraction steps, done is high in the cycle that starts n+1 rising edges after the edge that samples start.
REQ-024 Zero-operand latency: done is high in the cycle immediately after the sampling edge.
REQ-025 start is ignored in CALC and DONE; it is neither queued nor flagged.
REQ-026 start held high continuously -> a new operation is accepted in the first IDLE cycle after DONE.
REQ-027 busy=1 in CALC and DONE, and 0 in IDLE.
REQ-028 gcd, iter and err change only on the edge that enters DONE.
REQ-029 xin and yin are don't-care except on the sampling edge.

Reset
REQ-030 clr=1 on a rising edge -> state=IDLE, x=0, y=0, step counter=0, gcd=0, iter=0, err=0.
REQ-031 During and after reset, until the next accepted start: done=0 and busy=0.
REQ-032 clr overrides start and any in-progress CALC or DONE in the same cycle; the aborted result is discarded and never reported.
REQ-033 No output SHALL depend on clr combinationally.

Verification
REQ-034 W=8, xin=12, yin=18, start for 1 cycle -> steps 18->6 and 12->6; done 3 cycles after the sampling edge; gcd=6, iter=2, err=0.
REQ-035 W=8, xin=0, yin=9 -> done in the next cycle, gcd=9, iter=0, err=0; xin=0, yin=0 -> done next cycle, gcd=0, err=1.
REQ-036 W=8, xin=255, yin=1 -> done 255 cycles after the sampling edge, gcd=1, iter=254; busy high throughout.
REQ-037 W=8, xin=20, yin=20 -> done 1 cycle after the sampling edge, gcd=20, iter=0.
REQ-038 Start (255,1), raise start again at cycle 5, then assert clr at cycle 10 -> second start ignored; after clr busy=0, done=0, gcd=0, iter=0; a following start (8,12) -> gcd=4 with no residue from the aborted operation.
REQ-039 Randomised W=4 and W=8 operand pairs checked against a reference GCD; done is exactly one cycle wide and latency equals iter+1 for every nonzero pair.
